// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the 32x32 register file.
// Handshake: a transfer happens on a rising edge when valid && ready are both high.
// The requester holds addr/data stable and valid high until it sees ready.
// The scheduler grants at most one transfer per cycle. The accepted write appears
// on rf_we/rf_waddr/rf_wdata one cycle later.
// After reset, an init sequencer owns the port and writes registers 0..NREGS-1 once.
// Only then are the requesters served, round-robin between A (ALU) and B (load).
module regfile_write_sched #(
   parameter int NREGS       = 32,
   parameter int INIT_MODE   = 1,
   parameter int R0_WRITABLE = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [4:0]       a_addr,
   input  logic [31:0]      a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [4:0]       b_addr,
   input  logic [31:0]      b_data,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic             init_done,
   output logic [CNT_W-1:0] conflict_cnt,
   output logic             dbg_run
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

   state_t      state;
   logic [4:0]  init_cnt;
   logic        last_b;      // 1 when B received the most recent grant
   logic        run;
   logic        both;
   logic        grant_a;
   logic        grant_b;
   logic [4:0]  sel_addr;
   logic [31:0] sel_data;

   // Grant decision. A tie goes to whichever requester was not granted last.
   always_comb begin
      run      = rst && (state == ST_RUN);
      both     = a_valid && b_valid;
      grant_a  = run && a_valid && (!b_valid || last_b);
      grant_b  = run && b_valid && (!a_valid || !last_b);
      sel_addr = grant_a ? a_addr : b_addr;
      sel_data = grant_a ? a_data : b_data;
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;
   assign dbg_run = (state == ST_RUN);

   // Sequencer and arbiter state. All write-port outputs are registered here.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_INIT;
         init_cnt     <= '0;
         last_b       <= 1'b1;
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         init_done    <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               rf_we    <= 1'b1;
               rf_waddr <= init_cnt;
               rf_wdata <= (INIT_MODE != 0) ? {27'd0, init_cnt} : 32'd0;
               init_cnt <= init_cnt + 5'd1;
               if (init_cnt == LAST_IDX) begin
                  state     <= ST_RUN;
                  init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               // A write to r0 is still a transfer, but it never reaches the file.
               rf_we <= (grant_a || grant_b) && ((sel_addr != 5'd0) || (R0_WRITABLE != 0));
               if (grant_a || grant_b) begin
                  rf_waddr <= sel_addr;
                  rf_wdata <= sel_data;
                  last_b   <= grant_b;
               end
               if (both && (conflict_cnt != {CNT_W{1'b1}})) begin
                  conflict_cnt <= conflict_cnt + CNT_W'(1);
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for regfile_write_sched. It runs directed scenarios with literal expectations,
// followed by a randomized run with random mid-run resets. A rule-level model checks
// every cycle. A second instance with a 2-bit conflict counter checks saturation.
module tb_regfile_write_sched;

   localparam int NREGS = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [4:0]  a_addr = '0, b_addr = '0;
   logic [31:0] a_data = '0, b_data = '0;

   logic        a_ready, b_ready, rf_we, init_done, dbg_run;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [15:0] conflict_cnt;

   logic        s_a_ready, s_b_ready, s_rf_we, s_init_done, s_dbg_run;
   logic [4:0]  s_rf_waddr;
   logic [31:0] s_rf_wdata;
   logic [1:0]  s_conflict_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // clock
   always #5 clk = ~clk;

   regfile_write_sched #(.NREGS(NREGS), .INIT_MODE(1), .R0_WRITABLE(0), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .init_done(init_done), .conflict_cnt(conflict_cnt), .dbg_run(dbg_run)
   );

   regfile_write_sched #(.NREGS(NREGS), .INIT_MODE(1), .R0_WRITABLE(0), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(s_a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(s_b_ready), .b_addr(b_addr), .b_data(b_data),
      .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
      .init_done(s_init_done), .conflict_cnt(s_conflict_cnt), .dbg_run(s_dbg_run)
   );

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model + scoreboard ----------------
   bit          m_valid = 0;
   bit          m_run = 0;
   bit          m_last_b = 1;
   bit          m_we = 0;
   bit          m_done = 0;
   int          m_idx = 0;
   int          m_conf = 0;
   int          m_conf2 = 0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;
   logic [36:0] exp_q[$];

   always @(negedge clk) begin
      logic ea, eb;
      logic [36:0] w;
      // outputs produced by the last edge
      if (m_valid) begin
         chk("rf_we", rf_we, m_we);
         chk("rf_waddr", rf_waddr, m_waddr);
         chk("rf_wdata", rf_wdata, m_wdata);
         chk("init_done", init_done, m_done);
         chk("conflict_cnt", conflict_cnt, m_conf[15:0]);
         chk("sat_conflict_cnt", s_conflict_cnt, m_conf2[1:0]);
         chk("dbg_run", dbg_run, m_run);
         if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_unexpected_write", 1, 0);
            else begin
               w = exp_q.pop_front();
               chk("sb_write", {rf_waddr, rf_wdata}, w);
            end
         end
      end
      // expected readies for the inputs now applied
      ea = 1'b0;
      eb = 1'b0;
      if (rst && m_valid && m_run) begin
         if (a_valid && b_valid) begin
            ea = m_last_b;
            eb = !m_last_b;
         end else begin
            ea = a_valid;
            eb = b_valid;
         end
      end
      chk("a_ready", a_ready, ea);
      chk("b_ready", b_ready, eb);
      // prediction for the coming edge
      if (!rst) begin
         m_valid = 1; m_run = 0; m_idx = 0; m_last_b = 1; m_we = 0;
         m_waddr = '0; m_wdata = '0; m_done = 0; m_conf = 0; m_conf2 = 0;
         exp_q.delete();
      end else if (m_valid) begin
         if (!m_run) begin
            m_we    = 1;
            m_waddr = 5'(m_idx);
            m_wdata = 32'(m_idx);
            exp_q.push_back({m_waddr, m_wdata});
            if (m_idx == NREGS - 1) begin
               m_run  = 1;
               m_done = 1;
            end
            m_idx++;
         end else begin
            if (a_valid && b_valid) begin
               if (m_conf < 65535) m_conf++;
               if (m_conf2 < 3) m_conf2++;
            end
            if (ea || eb) begin
               m_last_b = eb;
               m_waddr  = ea ? a_addr : b_addr;
               m_wdata  = ea ? a_data : b_data;
               m_we     = (m_waddr != 5'd0);
               if (m_we) exp_q.push_back({m_waddr, m_wdata});
            end else begin
               m_we = 0;
            end
         end
      end
   end

   // ---------------- directed + random driver ----------------
   task automatic run_init();
      for (int i = 0; i < NREGS; i++) begin
         cyc();
         chk("init_we", rf_we, 1);
         chk("init_addr", rf_waddr, i);
         chk("init_data", rf_wdata, i);
         chk("init_done_edge", init_done, (i == NREGS - 1));
         chk("init_a_ready", a_ready, (i == NREGS - 1));
      end
   endtask

   initial begin
      bit a_acc, b_acc;
      // reset with A already requesting
      rst = 0; a_valid = 1; a_addr = 5'd7; a_data = 32'h11;
      cyc(); cyc();
      chk("rst_we", rf_we, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_conflict", conflict_cnt, 0);
      rst = 1;
      run_init();
      cyc();
      chk("held_a_we", rf_we, 1);
      chk("held_a_addr", rf_waddr, 7);
      chk("held_a_data", rf_wdata, 32'h11);
      a_valid = 0;

      // A only
      a_addr = 5'd5; a_data = 32'hDEADBEEF; a_valid = 1;
      #1 chk("a_only_ready", a_ready, 1);
      cyc();
      chk("a_only_we", rf_we, 1);
      chk("a_only_addr", rf_waddr, 5);
      chk("a_only_data", rf_wdata, 32'hDEADBEEF);
      a_valid = 0;
      cyc();
      chk("idle_we", rf_we, 0);
      chk("idle_addr_hold", rf_waddr, 5);

      // B only, so the next tie starts with A
      b_addr = 5'd12; b_data = 32'hC; b_valid = 1;
      #1 chk("b_only_ready", b_ready, 1);
      cyc();
      chk("b_only_addr", rf_waddr, 12);
      b_valid = 0;

      // both held for 4 cycles: A,B,A,B
      a_addr = 5'd3; a_data = 32'hA3; b_addr = 5'd9; b_data = 32'hB9;
      a_valid = 1; b_valid = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("tie_a_ready", a_ready, (k % 2 == 0));
         chk("tie_b_ready", b_ready, (k % 2 == 1));
         cyc();
         chk("tie_addr", rf_waddr, (k % 2 == 0) ? 3 : 9);
      end
      a_valid = 0; b_valid = 0;
      chk("conflict_4", conflict_cnt, 4);
      chk("sat_conflict_3", s_conflict_cnt, 3);

      // write to r0 is accepted but suppressed
      b_addr = 5'd0; b_data = 32'h55; b_valid = 1;
      #1 chk("r0_b_ready", b_ready, 1);
      cyc();
      chk("r0_we", rf_we, 0);
      a_addr = 5'd20; a_data = 32'h2020; b_addr = 5'd21; b_data = 32'h2121;
      a_valid = 1; b_valid = 1;
      #1;
      chk("after_r0_a_ready", a_ready, 1);
      chk("after_r0_b_ready", b_ready, 0);
      cyc();
      chk("after_r0_addr", rf_waddr, 20);
      a_valid = 0;
      cyc();
      chk("after_r0_b_addr", rf_waddr, 21);
      b_valid = 0;
      chk("conflict_5", conflict_cnt, 5);
      chk("sat_conflict_hold", s_conflict_cnt, 3);

      // reset mid-run with A pending
      a_addr = 5'd17; a_data = 32'h1717; a_valid = 1; rst = 0;
      #1 chk("mid_rst_a_ready", a_ready, 0);
      cyc();
      chk("mid_rst_we", rf_we, 0);
      chk("mid_rst_addr", rf_waddr, 0);
      chk("mid_rst_data", rf_wdata, 0);
      chk("mid_rst_done", init_done, 0);
      chk("mid_rst_conflict", conflict_cnt, 0);
      rst = 1;
      run_init();
      cyc();
      chk("reinit_a_addr", rf_waddr, 17);
      chk("reinit_a_data", rf_wdata, 32'h1717);
      a_valid = 0;

      // randomized traffic, requesters honour hold-until-ready
      for (int n = 0; n < 1500; n++) begin
         #1;
         a_acc = a_valid && a_ready;
         b_acc = b_valid && b_ready;
         cyc();
         if (!a_valid || a_acc) begin
            a_valid = 1'($urandom_range(0, 1));
            a_addr  = 5'($urandom_range(0, 31));
            a_data  = $urandom;
         end
         if (!b_valid || b_acc) begin
            b_valid = 1'($urandom_range(0, 1));
            b_addr  = 5'($urandom_range(0, 31));
            b_data  = $urandom;
         end
         rst = ($urandom_range(0, 399) != 0);
      end
      a_valid = 0; b_valid = 0; rst = 1;
      cyc(); cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
